// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: computes at issue, holds the result in shadow registers
// for a per-class latency, then commits to HI/LO. Optional MADD/MADDU under `MD_MADD_EN.
module md_scheduler #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [3:0]  issue_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_e;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        timed_op, is_div, mul_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, div_q, div_r;
  logic [31:0] res_hi, res_lo;
  logic        accept;

  always_comb begin
    timed_op = (issue_op == OP_MULT) || (issue_op == OP_MULTU) ||
               (issue_op == OP_DIV)  || (issue_op == OP_DIVU);
`ifdef MD_MADD_EN
    timed_op = timed_op || (issue_op == OP_MADD) || (issue_op == OP_MADDU);
`endif
  end

  assign is_div  = (issue_op == OP_DIV) || (issue_op == OP_DIVU);
  assign mul_sgn = (issue_op == OP_MULT) || (issue_op == OP_MADD);

  // Sign-extending to 64 bits lets one unsigned multiplier serve both signednesses.
  assign mul_a = {{32{mul_sgn & op_a[31]}}, op_a};
  assign mul_b = {{32{mul_sgn & op_b[31]}}, op_b};
  assign prod  = mul_a * mul_b;

  // Magnitude division; 0x80000000 / -1 naturally yields q=0x80000000, r=0.
  assign div_sgn = (issue_op == OP_DIV);
  assign a_neg   = div_sgn & op_a[31];
  assign b_neg   = div_sgn & op_b[31];
  assign a_mag   = a_neg ? -op_a : op_a;
  assign b_mag   = b_neg ? -op_b : op_b;
  assign uq      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign ur      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;

  always_comb begin
    div_q = (a_neg ^ b_neg) ? -uq : uq;
    div_r = a_neg ? -ur : ur;
    if (op_b == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = op_a;
    end
  end

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_hi = div_r;
      res_lo = div_q;
    end
`ifdef MD_MADD_EN
    if ((issue_op == OP_MADD) || (issue_op == OP_MADDU))
      {res_hi, res_lo} = {hi_q, lo_q} + prod;
`endif
  end

  assign accept    = (state_q == IDLE) && issue_valid && timed_op;
  assign start     = accept;
  assign stall_req = d_is_md & (accept | busy_q);
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = is_div ? DIV_RUN : MUL_RUN;
          cnt_d     = is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          busy_d    = 1'b1;
          done_d    = (cnt_d == 4'd1);
        end else if (issue_valid && issue_op == OP_MTHI) begin
          hi_d = op_a;
        end else if (issue_valid && issue_op == OP_MTLO) begin
          lo_d = op_a;
        end
      end
      MUL_RUN, DIV_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          busy_d  = 1'b0;
        end else begin
          done_d = (cnt_q == 4'd2);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed + random bench for md_scheduler against a cycle-indexed behavioural model.
module tb_md_scheduler;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_op = 4'd0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        d_is_md = 1'b0;
  logic        start, busy, done, stall_req;
  logic [31:0] hi, lo;

  md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
    .op_a(op_a), .op_b(op_b), .d_is_md(d_is_md), .start(start), .busy(busy),
    .done(done), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, stall_cnt = 0;
  // model: architectural regs plus the one in-flight op, identified by its done cycle
  logic [31:0] m_hi = 0, m_lo = 0;
  bit          m_active = 0;
  int          m_end = 0;
  logic [63:0] m_pend = 0;

`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a, b,
                                       input logic [31:0] h, l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    case (op)
      4'd0: return 64'(sa * sb);
      4'd1: return ua * ub;
      4'd2, 4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 4'd2) begin q = sa / sb; r = sa % sb; end
        else begin q = longint'(ua / ub); r = longint'(ua % ub); end
        return {r[31:0], q[31:0]};
      end
      4'd6: return {h, l} + 64'(sa * sb);
      4'd7: return {h, l} + ua * ub;
      default: return 64'd0;
    endcase
  endfunction

  // One clock: drive, compare at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, b,
                      input logic dmd);
    bit timed, acc;
    issue_valid = v; issue_op = op; op_a = a; op_b = b; d_is_md = dmd;
    @(negedge clk);
    timed = (op <= 4'd3) || (MADD && (op == 4'd6 || op == 4'd7));
    acc   = v && timed && !m_active;
    check("start", 64'(start), 64'(acc));
    check("busy",  64'(busy),  64'(m_active));
    check("done",  64'(done),  64'(m_active && cyc == m_end));
    check("stall", 64'(stall_req), 64'(dmd && (acc || m_active)));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    if (stall_req) stall_cnt++;
    @(posedge clk);
    if (m_active && cyc == m_end) begin
      {m_hi, m_lo} = m_pend;
      m_active = 0;
    end else if (acc) begin
      m_pend   = calc(op, a, b, m_hi, m_lo);
      m_active = 1;
      m_end    = cyc + ((op == 4'd2 || op == 4'd3) ? DIV_LAT : MULT_LAT);
    end else if (v && !m_active && op == 4'd4) m_hi = a;
    else if (v && !m_active && op == 4'd5) m_lo = a;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic dmd);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, dmd);
  endtask

  initial begin
    logic [31:0] ra, rb;
    // reset state
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi",   64'(hi),   64'(0));
    check("rst_lo",   64'(lo),   64'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // MULT -2 x 3
    step(1, 4'd0, 32'hFFFF_FFFE, 32'd3, 0);
    idle(MULT_LAT, 0);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    // DIVU 100/7 with D stage holding an md op: stall for issue + 10 busy cycles
    stall_cnt = 0;
    step(1, 4'd3, 32'd100, 32'd7, 1);
    idle(DIV_LAT + 1, 1);
    check("divu_stall_cnt", 64'(stall_cnt), 64'(DIV_LAT + 1));
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    step(1, 4'd2, 32'hFFFF_FFF9, 32'd2, 0);
    idle(DIV_LAT, 0);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    step(1, 4'd2, 32'd5, 32'd0, 0);
    idle(DIV_LAT, 0);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'd5);

    step(1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(DIV_LAT, 0);
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);

    // MTLO: immediate, no busy
    step(1, 4'd5, 32'h1234, 32'd0, 0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    idle(1, 0);

    // MULT issued while busy is dropped; back-to-back issue right after commit
    step(1, 4'd1, 32'd10, 32'd10, 0);
    step(1, 4'd1, 32'd7, 32'd7, 0);
    idle(MULT_LAT - 1, 0);
    step(1, 4'd1, 32'd3, 32'd4, 0);
    check("ignored_lo", 64'(lo), 64'd100);
    idle(MULT_LAT, 0);
    check("b2b_lo", 64'(lo), 64'd12);

    // Async reset in busy cycle 3 of a DIV
    step(1, 4'd2, 32'd50, 32'd3, 0);
    idle(2, 0);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi",   64'(hi),   64'(0));
    check("abort_lo",   64'(lo),   64'(0));
    m_active = 0; m_hi = 0; m_lo = 0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); cyc++; #1;
    step(1, 4'd1, 32'd2, 32'd3, 0);
    idle(MULT_LAT, 0);
    check("post_rst_lo", 64'(lo), 64'd6);

    // MADDU 1x1 onto {0, FFFFFFFF}
    step(1, 4'd4, 32'd0, 32'd0, 0);
    step(1, 4'd5, 32'hFFFF_FFFF, 32'd0, 0);
    step(1, 4'd7, 32'd1, 32'd1, 0);
    idle(MULT_LAT, 0);
    check("madd_hi", 64'(hi), MADD ? 64'd1 : 64'd0);
    check("madd_lo", 64'(lo), MADD ? 64'd0 : 64'hFFFF_FFFF);

    // Random traffic, biased towards edge operands
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      step(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), ra, rb,
           1'($urandom_range(0, 1)));
    end
    idle(DIV_LAT + 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide scheduler for the pipelined MIPS core. Accepts one mult/div-class operation per issue from the E stage, holds the computed result in shadow registers for a fixed per-class latency, asserts `busy` while the operation is in flight, commits to HI/LO on completion, and raises the D-stage stall request that holds back any mult/div-class instruction while the unit is occupied.

## Interface
Parameters:
- `MULT_LAT`, 5: cycles `busy` is high for MULT/MULTU (and MADD/MADDU); legal range 1–15.
- `DIV_LAT`, 10: cycles `busy` is high for DIV/DIVU; legal range 1–15.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `issue_valid`  in  1  E stage presents an md operation this cycle.
- `issue_op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU; all others illegal.
- `op_a`  in  32  forwarded rs value.
- `op_b`  in  32  forwarded rt value.
- `d_is_md`  in  1  D stage holds MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO/MADD/MADDU.
- `start`  out  1  combinational: `issue_valid` and a timed op (0–3, 6–7) accepted this cycle.
- `busy`  out  1  registered: timed operation in flight.
- `done`  out  1  registered: high in the last busy cycle.
- `stall_req`  out  1  `d_is_md & (start | busy)`.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN. A 4-bit down-counter `cnt` tracks the remaining cycles.
- In IDLE, a timed op is accepted when `issue_valid` is high. The result is computed from `op_a`/`op_b` in the issue cycle and latched into `pend_hi`/`pend_lo`. `cnt` loads `MULT_LAT` or `DIV_LAT`, and the state moves to MUL_RUN or DIV_RUN.
- In RUN, `cnt` decrements each cycle. When `cnt==1`, `done` is high. At the end of that cycle `hi<=pend_hi`, `lo<=pend_lo`, and the state returns to IDLE.
- MULT/MULTU: {hi,lo} = signed/unsigned 64-bit product.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divisor 0: lo = 32'hFFFF_FFFF and hi = `op_a`. Latency is unchanged.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
- MTHI/MTLO in IDLE: write `op_a` to hi/lo at the edge. No busy cycle, `start` stays 0.
- Any `issue_valid` while `busy` is ignored (stall_req prevents this in a correct pipeline). Illegal opcodes are ignored.
- MFHI/MFLO read `hi`/`lo` directly. They are stalled by `stall_req` until commit.

## Timing
- Reset values: state IDLE, `cnt`=0, `hi`=`lo`=0, `pend_*`=0, `busy`=`done`=0. `start` and `stall_req` are 0 unless their inputs drive them.
- For an issue in cycle t: `busy` is high in cycles t+1 … t+LAT, `done` is high in cycle t+LAT, and the new hi/lo are visible from cycle t+LAT+1.
- Back-to-back: a new issue is accepted in cycle t+LAT+1 (the first IDLE cycle). No bubble is required beyond that.
- `stall_req` is high in the issue cycle and every busy cycle when `d_is_md`=1. It is low in cycle t+LAT+1.
- Reset asserted mid-operation aborts immediately: hi/lo clear to 0 and the pending result is lost.
- MTHI issued in the same cycle that a RUN commit would occur cannot happen (busy blocks issue). Commit always wins.

## Configuration
- `MD_MADD_EN` defined: opcodes 6/7 are accepted. {hi,lo} ← {hi,lo} + signed/unsigned product, computed using hi/lo at the issue cycle, with `MULT_LAT` latency and wrap modulo 2^64.
- Not defined: opcodes 6/7 are illegal and ignored (`start`=0, no state change).

## Test plan
- MULT 32'hFFFF_FFFE × 3 → busy for 5 cycles, done in cycle 5; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA in cycle 6.
- DIVU 100 / 7 with `d_is_md`=1 throughout → stall_req high for 11 cycles (issue + 10); lo=14, hi=2 after commit.
- DIV -7 / 2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV 5 / 0 → lo=32'hFFFF_FFFF, hi=5.
- MTLO 32'h1234 in IDLE → lo=32'h1234 next cycle, busy never asserted. MULT issued while busy → ignored and original result commits.
- Reset pulled low in busy cycle 3 of DIV → busy=0 and hi=lo=0 immediately. After release, a MULTU 2×3 gives lo=6.
- `MD_MADD_EN`: hi=0, lo=32'hFFFF_FFFF, MADDU 1×1 → hi=1, lo=0. Without the macro, the same issue gives start=0 and hi/lo are unchanged.
